hir_bram_stream_rd: RTL and testbench

Read-side streaming front end for the dual-port block RAM primitive: accepts a (base, length) command, walks the RAM read port sequentially, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream. It sits between a HIR-generated consumer and the read port (`p0_*`) of `bram_r1_w1`. It sustains one word per cycle under full downstream readiness and never drops a word under backpressure.

---
 rtl/hir_bram_stream_pkg.sv | 19 +
 rtl/hir_skid_buf2.sv | 61 ++++++
 rtl/hir_bram_stream_rd.sv | 164 ++++++++++++++++
 tb/tb_hir_bram_stream_rd.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hir_bram_stream_pkg.sv
// hir_bram_stream_pkg
//   Shared definitions for the BRAM read-stream front end.
//   - state_t   : controller state (IDLE, RUN, DRAIN)
//   - BUF_DEPTH : output buffer depth. Two entries are enough to absorb the
//                 one-cycle RAM read latency at full throughput.
//   The buffer entry struct is declared in hir_bram_stream_rd, because it is
//   sized by that module's ELEMENT_WIDTH parameter. It carries an extra last
//   bit only when HIR_BRAM_RD_LAST_EN is defined.
package hir_bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/hir_skid_buf2.sv
// hir_skid_buf2
//   Two-entry valid/ready buffer, organised as a circular FIFO. The head
//   entry is read straight from a register, so head_data stays stable until
//   it is popped.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     push, push_data write one entry (accepted when not full, or when full
//                     with a simultaneous pop)
//     pop             retire the head entry (ignored when empty)
//     head_data       oldest entry
//     count           occupancy, 0..2
//     full, empty     occupancy flags
module hir_skid_buf2
  import hir_bram_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'(BUF_DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // When full, the pop frees the slot that wr_ptr points at in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/hir_bram_stream_rd.sv
// hir_bram_stream_rd
//   Read-side stream front end for port p0 of bram_r1_w1. It takes a
//   (base, length) command, reads the RAM sequentially, absorbs the one-cycle
//   registered read latency, and presents the words as a valid/ready stream.
//   Throughput is one word per cycle while the consumer is ready.
//   Optional feature macro: HIR_BRAM_RD_LAST_EN adds the out_last port.
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. A valid source holds its payload stable and keeps valid
//   asserted until that transfer occurs. Ready may change freely.
//   Ports:
//     clk, rst                     clock, asynchronous active-low reset
//     cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//     cmd_base, cmd_len            first address, word count (0 is legal)
//     out_valid/out_ready/out_data output stream
//     out_last                     final word of a command (macro only)
//     busy                         a command is in progress
//     p0_addr_en, p0_rd_en         RAM port enables (identical)
//     p0_addr_data                 RAM read address
//     p0_rd_data                   RAM data, valid one cycle after the address
//     dbg_state                    current controller state
module hir_bram_stream_rd
  import hir_bram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int ELEMENT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_base,
  input  logic [ADDR_WIDTH:0]      cmd_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ELEMENT_WIDTH-1:0] out_data,
`ifdef HIR_BRAM_RD_LAST_EN
  output logic                     out_last,
`endif
  output logic                     busy,
  output logic                     p0_addr_en,
  output logic [ADDR_WIDTH-1:0]    p0_addr_data,
  output logic                     p0_rd_en,
  input  logic [ELEMENT_WIDTH-1:0] p0_rd_data,
  output state_t                   dbg_state
);

`ifdef HIR_BRAM_RD_LAST_EN
  typedef struct packed {
    logic                     last;
    logic [ELEMENT_WIDTH-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic [ELEMENT_WIDTH-1:0] data;
  } entry_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     remain_q;
  logic                    inflight_q;
  logic                    cmd_ready_q;

  logic [1:0]              buf_count;
  logic                    buf_full;
  logic                    buf_empty;
  entry_t                  push_entry;
  entry_t                  head_entry;
  logic                    pop;
  logic                    issue;
  logic [2:0]              occ_after_pop;

  assign pop = out_valid & out_ready;

  // Buffer occupancy once this cycle's capture and pop have settled. A new
  // read is issued only if its data will still have a slot next cycle.
  assign occ_after_pop = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (remain_q != '0) && (occ_after_pop < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        IDLE: begin
          // A zero-length command is consumed here without leaving IDLE.
          if (cmd_valid && cmd_ready_q && (cmd_len != '0)) begin
            addr_q      <= cmd_base;
            remain_q    <= cmd_len;
            state_q     <= RUN;
            cmd_ready_q <= 1'b0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            addr_q   <= addr_q + ADDR_ONE;
            remain_q <= remain_q - LEN_ONE;
            if (remain_q == LEN_ONE) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once the buffer drains this cycle and nothing is in flight,
          // so IDLE is reached the cycle after the final pop.
          if (!inflight_q && (buf_count == {1'b0, pop})) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HIR_BRAM_RD_LAST_EN
  logic last_inflight_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_inflight_q <= 1'b0;
    else      last_inflight_q <= issue && (remain_q == LEN_ONE);
  end

  assign push_entry.last = last_inflight_q;
  assign out_last        = head_entry.last & ~buf_empty;
`endif

  assign push_entry.data = p0_rd_data;

  hir_skid_buf2 #(
    .WIDTH ($bits(entry_t))
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // The issue rule must never leave a capture with no slot to land in.
  assert property (@(posedge clk) disable iff (!rst) !(buf_full && inflight_q && !pop));

  assign cmd_ready    = cmd_ready_q;
  assign out_valid    = ~buf_empty;
  assign out_data     = head_entry.data;
  assign busy         = (state_q != IDLE);
  assign p0_addr_en   = issue;
  assign p0_rd_en     = issue;
  assign p0_addr_data = addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hir_bram_stream_rd.sv
// tb_hir_bram_stream_rd
//   Directed bench for hir_bram_stream_rd with ADDR_WIDTH=4 (16-word RAM,
//   mem[i] = 0x100 + i). Checks out_last when HIR_BRAM_RD_LAST_EN is defined.
module tb_hir_bram_stream_rd;
  import hir_bram_stream_pkg::*;

  localparam int AW = 4;
  localparam int EW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [EW-1:0] out_data;
`ifdef HIR_BRAM_RD_LAST_EN
  logic          out_last;
`endif
  logic          busy;
  logic          p0_addr_en;
  logic [AW-1:0] p0_addr_data;
  logic          p0_rd_en;
  logic [EW-1:0] p0_rd_data = '0;
  state_t        dbg_state;

  always #5 clk = ~clk;

  hir_bram_stream_rd #(
    .ADDR_WIDTH    (AW),
    .ELEMENT_WIDTH (EW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef HIR_BRAM_RD_LAST_EN
    .out_last     (out_last),
`endif
    .busy         (busy),
    .p0_addr_en   (p0_addr_en),
    .p0_addr_data (p0_addr_data),
    .p0_rd_en     (p0_rd_en),
    .p0_rd_data   (p0_rd_data),
    .dbg_state    (dbg_state)
  );

  // RAM model: registered read, one cycle latency.
  logic [EW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 16'h100 + 16'(i);
  always @(posedge clk) if (p0_rd_en) p0_rd_data <= mem[p0_addr_data];

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic          exp_last_q[$];
  int            pop_cnt = 0;
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_stable", out_data, prev_data);
      end
      if (p0_addr_en || p0_rd_en) check("rd_en_eq_addr_en", p0_rd_en, p0_addr_en);
      if (p0_addr_en) begin
        if (exp_addr_q.size() == 0) check("addr_unexpected_issue", exp_addr_q.size(), 1);
        else check("addr_seq", p0_addr_data, exp_addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("data_unexpected_word", exp_q.size(), 1);
        else begin
          check("data_seq", out_data, exp_q.pop_front());
`ifdef HIR_BRAM_RD_LAST_EN
          check("last_seq", out_last, exp_last_q.pop_front());
`else
          void'(exp_last_q.pop_front());
`endif
        end
      end
      outstanding = outstanding + int'(p0_addr_en) - int'(out_valid && out_ready);
      check("outstanding_le2", outstanding <= 2, 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  logic [3:0] bp_pat = 4'b1001;  // out_ready = 1,0,0,1 (bit index = cycle % 4)

  task automatic expect_cmd(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(16'h100 + 16'(a));
      exp_last_q.push_back(i == len - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_addr_en", p0_addr_en, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_cmd_ready", cmd_ready, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] base, input int len, input bit bp);
    int  start_pops;
    bit  done;
    expect_cmd(base, len);
    start_pops = pop_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = base; cmd_len = (AW + 1)'(len); out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    done = 1'b0;
    for (int c = 1; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      out_ready = bp ? bp_pat[c % 4] : 1'b1;
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check({tag, "_finished"}, done, 1);
    check({tag, "_word_count"}, pop_cnt - start_pops, len);
    check({tag, "_data_drained"}, exp_q.size(), 0);
    check({tag, "_addr_drained"}, exp_addr_q.size(), 0);
    check({tag, "_idle_ready"}, cmd_ready, 1);
  endtask

  // ---------------- tests ----------------
  task automatic test_basic();
    expect_cmd(4'd4, 3);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 4'd4; cmd_len = 5'd3; out_ready = 1'b1;
    @(negedge clk);
    check("basic_c0_cmd_ready", cmd_ready, 1);
    check("basic_c0_busy", busy, 0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("basic_c%0d_valid", c), out_valid, (c >= 3 && c <= 5));
      check($sformatf("basic_c%0d_busy", c), busy, (c < 6));
      if (c == 1) begin
        check("basic_c1_addr_en", p0_addr_en, 1);
        check("basic_c1_state", dbg_state, RUN);
      end
      if (c >= 3 && c <= 5) begin
        check($sformatf("basic_c%0d_data", c), out_data, 16'h101 + 16'(c));
`ifdef HIR_BRAM_RD_LAST_EN
        check($sformatf("basic_c%0d_last", c), out_last, (c == 5));
`endif
      end
    end
    check("basic_c6_cmd_ready", cmd_ready, 1);
    check("basic_drained", exp_q.size(), 0);
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 4'd3; cmd_len = 5'd0; out_ready = 1'b1;
    @(negedge clk);
    check("zero_c0_cmd_ready", cmd_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("zero_c%0d_cmd_ready", c), cmd_ready, 1);
      check($sformatf("zero_c%0d_busy", c), busy, 0);
      check($sformatf("zero_c%0d_valid", c), out_valid, 0);
      check($sformatf("zero_c%0d_addr_en", c), p0_addr_en, 0);
    end
  endtask

  task automatic test_reset_mid_run();
    int  start_pops;
    bit  hit;
    expect_cmd(4'd0, 16);
    start_pops = pop_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 4'd0; cmd_len = 5'd16; out_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (pop_cnt - start_pops == 5) hit = 1'b1;
    end
    check("rstmid_reached_5_pops", hit, 1);
    rst = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_data", out_data, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_cmd_ready", cmd_ready, 0);
    check("rstmid_addr_en", p0_addr_en, 0);
    check("rstmid_addr", p0_addr_data, 0);
    exp_q.delete();
    exp_addr_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    run_cmd("rstmid_after", 4'd0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int  start_pops;
    bit  done;
    expect_cmd(4'd2, 3);
    expect_cmd(4'd8, 2);
    start_pops = pop_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 4'd2; cmd_len = 5'd3; out_ready = 1'b1;
    @(negedge clk);
    check("b2b_c0_cmd_ready", cmd_ready, 1);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin cmd_base = 4'd8; cmd_len = 5'd2; end
      if (c == 7) cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b_c%0d_cmd_ready", c), cmd_ready, (c == 6));
      check($sformatf("b2b_c%0d_valid", c), out_valid, ((c >= 3 && c <= 5) || c == 9));
      if (c >= 3 && c <= 5) check($sformatf("b2b_c%0d_data", c), out_data, 16'h102 + 16'(c - 3));
      if (c == 9) check("b2b_c9_data", out_data, 16'h108);
    end
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check("b2b_finished", done, 1);
    check("b2b_word_count", pop_cnt - start_pops, 5);
    check("b2b_drained", exp_q.size(), 0);
  endtask

  initial begin
    do_reset();
    test_basic();
    run_cmd("wrap", 4'd14, 4, 1'b0);
    run_cmd("bp", 4'd5, 8, 1'b1);
    run_cmd("long_wrap", 4'd0, 18, 1'b0);
    test_zero();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
